value_display_decoder: RTL and testbench
========================================

// Module: value_display_decoder
// PURPOSE
//  Read side of the set-value path: takes the 40-bit binary value built up by the
//  switch/push-button setup logic and renders it on the six-digit 7-segment display.
//  Uses a sequential shift-add-3 (double-dabble) binary->BCD conversion, started by a
//  start/busy/done handshake, and drives per-digit active-low segment codes.
// PARAMETERS
//  VALUE_W   40  width of i_value in bits
//  DIGITS    6   number of decimal digits / display positions (max value 10^DIGITS-1)
//  BLANK_LZ  1   1 = blank leading zeros (digit 0 is never blanked); 0 = show all zeros
// PORTS
//  i_clk       in   1          system clock, all state on rising edge
//  i_rst_n     in   1          asynchronous active-low reset
//  i_value     in   VALUE_W    binary value to display, sampled only when start is accepted
//  i_start     in   1          request conversion; accepted only in IDLE
//  o_busy      out  1          1 while conversion is in progress (SHIFT or DONE)
//  o_done      out  1          one-cycle pulse: o_bcd/o_seg/o_overflow updated this cycle
//  o_overflow  out  1          latched: last accepted value >= 10^DIGITS
//  o_bcd       out  4*DIGITS   BCD digits; digit 0 (units) in bits [3:0]
//  o_seg       out  7*DIGITS   segments per digit, {g,f,e,d,c,b,a}, active-low; digit 0 in [6:0]
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state IDLE, o_busy=0, o_done=0, o_overflow=0, o_bcd=0,
//   every o_seg digit = 7'b1111111 (blank). Internal shift/BCD/counter registers cleared.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE : i_start=1 at edge k -> latch i_value into shift reg, clear BCD work reg,
//          counter=0, latch ovf = (i_value >= 10^DIGITS); go SHIFT. o_busy=1 from k.
//   SHIFT: each edge: every BCD nibble >= 5 gets +3, then {bcd,shift} shifted left 1
//          (MSB of value enters bit 0 of BCD). Exactly VALUE_W shifts; bits leaving
//          the top nibble are discarded. After shift VALUE_W go DONE.
//   DONE : at this edge o_bcd/o_seg/o_overflow are updated, o_done=1 for one cycle,
//          o_busy=0 after this cycle's edge; go IDLE.
//  Latency: start accepted at edge k -> o_done high in the cycle following edge
//   k+VALUE_W+1 (40-bit default: 41 edges). Outputs hold between conversions.
//  i_start while busy (SHIFT/DONE) is ignored, not queued. i_start high in IDLE on the
//   cycle after o_done starts a new conversion (back-to-back allowed).
//  Overflow: if ovf latched, o_overflow=1, o_bcd = all 4'h9, every o_seg digit shows '-'
//   (7'b0111111); blanking not applied. Otherwise o_overflow=0 and normal decode.
//  Segment map (gfedcba, low = lit): 0=1000000 1=1111001 2=0100100 3=0110000
//   4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000; nibble >9 -> blank.
//  Leading-zero blanking (BLANK_LZ=1): digit n>0 is blank iff it and all higher digits
//   are 0; o_bcd is never blanked. Value 0 shows a single '0' in digit 0.
//  Reset asserted mid-conversion: immediate return to reset state; no o_done is issued
//   for the aborted conversion.
// TESTING
//  1 reset, then start with i_value=0 -> o_done after 41 edges, o_bcd=24'h000000,
//    o_seg digit0=1000000, digits1-5=1111111, o_overflow=0.
//  2 i_value=123456 -> o_bcd=24'h123456, o_seg = {1111001,0100100,0110000,0011001,
//    0010010,0000010} (digit5..0); o_busy high 41 cycles, o_done exactly 1 cycle.
//  3 i_value=999999 -> o_bcd=24'h999999, o_overflow=0; then i_value=1000000 ->
//    o_overflow=1, o_bcd=24'h999999, all digits 0111111.
//  4 i_value=1005 (BLANK_LZ=1) -> o_bcd=24'h001005, digits 5,4 blank, digit2=1000000.
//  5 start 123 then pulse i_start with 456 at cycle 10 of busy -> single o_done with
//    o_bcd=24'h000123; next start after done converts 456 normally.
//  6 start 654321, assert i_rst_n=0 at cycle 20 -> outputs at reset values, no o_done;
//    release and start 42 -> o_bcd=24'h000042 after 41 edges.

Source files
------------

// File: rtl/value_display_decoder.sv
// Sequential double-dabble binary->BCD converter with a start/busy/done handshake,
// driving active-low 7-segment codes with optional leading-zero blanking.
module value_display_decoder #(
    parameter int unsigned VALUE_W  = 40,
    parameter int unsigned DIGITS   = 6,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [VALUE_W-1:0]    i_value,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [7*DIGITS-1:0]   o_seg
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SEG_W = 7 * DIGITS;
    localparam int unsigned CNT_W = $clog2(VALUE_W + 1);
    localparam logic [VALUE_W-1:0] LIMIT = VALUE_W'(10 ** DIGITS);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e               state_q;
    logic [VALUE_W-1:0]   shift_q;
    logic [BCD_W-1:0]     work_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ovf_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 overflow_q;
    logic [BCD_W-1:0]     bcd_q;
    logic [SEG_W-1:0]     seg_q;

    logic [BCD_W-1:0]     work_d;
    logic [BCD_W-1:0]     bcd_d;
    logic [SEG_W-1:0]     seg_d;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // One double-dabble step: add-3 correction then shift in the next value bit
    always_comb begin
        logic [BCD_W-1:0] adj;
        logic [3:0]       nib;
        adj = '0;
        nib = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            nib = work_q[4*i +: 4];
            adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        work_d = {adj[BCD_W-2:0], shift_q[VALUE_W-1]};
    end

    // Final display decode, scanning from the top digit so leading zeros can be blanked
    always_comb begin
        logic       lead;
        logic [3:0] nib;
        lead  = 1'b1;
        nib   = '0;
        bcd_d = ovf_q ? {DIGITS{4'h9}} : work_q;
        seg_d = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            nib = work_q[4*i +: 4];
            if (nib != 4'd0) begin
                lead = 1'b0;
            end
            if (ovf_q) begin
                seg_d[7*i +: 7] = SEG_DASH;
            end else if ((BLANK_LZ != 0) && lead && (i != 0)) begin
                seg_d[7*i +: 7] = SEG_BLANK;
            end else begin
                seg_d[7*i +: 7] = seg7(nib);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
            seg_q      <= {SEG_W{1'b1}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        shift_q <= i_value;
                        work_q  <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= (i_value >= LIMIT);
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    work_q  <= work_d;
                    shift_q <= {shift_q[VALUE_W-2:0], 1'b0};
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(VALUE_W - 1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_q      <= bcd_d;
                    seg_q      <= seg_d;
                    overflow_q <= ovf_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_overflow = overflow_q;
    assign o_bcd      = bcd_q;
    assign o_seg      = seg_q;

endmodule

// File: tb/tb_value_display_decoder.sv
// Directed bench for value_display_decoder: conversions, overflow, blanking,
// start-while-busy and reset-abort, with hand-computed expected values.
module tb_value_display_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [39:0] value = '0;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [23:0] bcd;
    logic [41:0] seg;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] B = 7'b1111111;
    localparam logic [6:0] D = 7'b0111111;

    value_display_decoder dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_value    (value),
        .i_start    (start),
        .o_busy     (busy),
        .o_done     (done),
        .o_overflow (ovf),
        .o_bcd      (bcd),
        .o_seg      (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_conv(input logic [39:0] v);
        value = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until o_done, bounded at 200
    task automatic wait_done(input int e0, output int edges, output int busy_cyc);
        edges    = e0;
        busy_cyc = busy ? 1 : 0;
        while (done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy === 1'b1) busy_cyc++;
        end
    endtask

    task automatic conv(input string tag, input logic [39:0] v, input logic [23:0] exp_bcd,
                        input logic [41:0] exp_seg, input logic exp_ovf);
        int e;
        int bc;
        start_conv(v);
        wait_done(0, e, bc);
        chk({tag, "_latency"}, 64'(e), 64'd41);
        chk({tag, "_busycyc"}, 64'(bc), 64'd41);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_bcd"}, 64'(bcd), 64'(exp_bcd));
        chk({tag, "_seg"}, 64'(seg), 64'(exp_seg));
        chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int e;
        int bc;
        int seen;

        // reset state
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_bcd", 64'(bcd), 64'd0);
        chk("rst_seg", 64'(seg), 64'h3FF_FFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        conv("zero", 40'd0, 24'h000000, {B, B, B, B, B, 7'b1000000}, 1'b0);
        conv("v123456", 40'd123456, 24'h123456,
             {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}, 1'b0);
        conv("v999999", 40'd999999, 24'h999999, {6{7'b0010000}}, 1'b0);
        conv("v1000000", 40'd1000000, 24'h999999, {D, D, D, D, D, D}, 1'b1);
        conv("vmax", 40'hFF_FFFF_FFFF, 24'h999999, {D, D, D, D, D, D}, 1'b1);
        conv("v1005", 40'd1005, 24'h001005,
             {B, B, 7'b1111001, 7'b1000000, 7'b1000000, 7'b0010010}, 1'b0);

        // outputs hold between conversions
        repeat (5) @(posedge clk);
        #1;
        chk("hold_bcd", 64'(bcd), 64'h001005);

        // start while busy is ignored
        start_conv(40'd123);
        repeat (9) @(posedge clk);
        #1;
        value = 40'd456;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(10, e, bc);
        chk("ign_latency", 64'(e), 64'd41);
        chk("ign_bcd", 64'(bcd), 64'h000123);
        chk("ign_seg", 64'(seg), 64'({B, B, B, 7'b1111001, 7'b0100100, 7'b0110000}));
        @(posedge clk);
        #1;
        chk("ign_single_done", 64'(done), 64'd0);
        chk("ign_idle", 64'(busy), 64'd0);
        conv("v456", 40'd456, 24'h000456, {B, B, B, 7'b0011001, 7'b0010010, 7'b0000010}, 1'b0);

        // reset mid-conversion aborts without o_done
        start_conv(40'd654321);
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_bcd", 64'(bcd), 64'd0);
        chk("abort_seg", 64'(seg), 64'h3FF_FFFF_FFFF);
        chk("abort_ovf", 64'(ovf), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        conv("v42", 40'd42, 24'h000042, {B, B, B, B, 7'b0011001, 7'b0100100}, 1'b0);

        // back-to-back start on the cycle after o_done
        start_conv(40'd7);
        wait_done(0, e, bc);
        value = 40'd80;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done(0, e, bc);
        chk("b2b_latency", 64'(e), 64'd41);
        chk("b2b_bcd", 64'(bcd), 64'h000080);
        chk("b2b_seg", 64'(seg), 64'({B, B, B, B, 7'b0000000, 7'b1000000}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
